// File: rtl/serial_subtractor_pkg.sv
// Shared definitions for the bit-serial subtractor: FSM state encoding,
// default sizing and the full-subtractor bit equations.
package serial_subtractor_pkg;

    localparam int DEFAULT_WIDTH = 8;
    localparam int DEFAULT_CNT_W = 4;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    // Difference bit of one full-subtractor column: x - y - bi.
    function automatic logic sub_diff(input logic x, input logic y, input logic bi);
        return x ^ y ^ bi;
    endfunction

    // Borrow out of one column: borrow when y exceeds x, or when the
    // operands are equal and a borrow is already pending from below.
    function automatic logic sub_borrow(input logic x, input logic y, input logic bi);
        return (~x & y) | (~(x ^ y) & bi);
    endfunction

endpackage

// File: rtl/serial_subtractor_fullsubtractor.sv
// Single combinational full-subtractor cell. Outputs come first in the
// port list so it lines up with the other ALU bit cells.
module serial_subtractor_fullsubtractor
    import serial_subtractor_pkg::*;
(
    output logic d,
    output logic bo,
    input  logic x,
    input  logic y,
    input  logic bi
);

    assign d  = sub_diff(x, y, bi);
    assign bo = sub_borrow(x, y, bi);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: d = a - b, LSB first, one bit per clock.
// The accepting edge loads the operands, the next WIDTH edges each resolve
// one bit through the shared full-subtractor cell, and the last of those
// edges publishes d/bout together with a one-cycle done pulse.
module serial_subtractor
    import serial_subtractor_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int CNT_W = DEFAULT_CNT_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] d,
    output logic             bout
);

    // The counter must be able to hold WIDTH-1, the index of the last bit.
    if (WIDTH < 2 || (1 << CNT_W) <= WIDTH) begin : g_param_check
        $error("serial_subtractor: need WIDTH >= 2 and 2**CNT_W > WIDTH");
    end

    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    state_t           state;
    state_t           state_next;
    logic             accept;
    logic             last_step;

    // Operand shift registers; bit 0 is the column being worked on.
    logic [WIDTH-1:0] sa;
    logic [WIDTH-1:0] sb;

    // Result bits resolved so far, entering at the MSB and moving down.
    // One bit short of WIDTH because the final bit goes straight into d.
    logic [WIDTH-2:0] res;
    logic [WIDTH-1:0] res_shift;

    logic [CNT_W-1:0] cnt;
    logic             borrow;

    logic             cell_diff;
    logic             cell_borrow;

    serial_subtractor_fullsubtractor u_cell (
        .d  (cell_diff),
        .bo (cell_borrow),
        .x  (sa[0]),
        .y  (sb[0]),
        .bi (borrow)
    );

    // Result as it would look after this edge's shift, also the final d.
    assign res_shift = {cell_diff, res};

    assign busy = (state == RUN);

    // Next-state decode: accept a request in IDLE, finish on the last bit.
    always_comb begin
        state_next = state;
        accept     = 1'b0;
        last_step  = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    accept     = 1'b1;
                    state_next = RUN;
                end
            end
            RUN: begin
                if (cnt == LAST_BIT) begin
                    last_step  = 1'b1;
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Datapath: load operands on accept, then shift one column per edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sa     <= '0;
            sb     <= '0;
            res    <= '0;
            cnt    <= '0;
            borrow <= 1'b0;
        end else if (accept) begin
            sa     <= a;
            sb     <= b;
            res    <= '0;
            cnt    <= '0;
            borrow <= 1'b0;
        end else if (state == RUN) begin
            sa     <= sa >> 1;
            sb     <= sb >> 1;
            res    <= res_shift[WIDTH-1:1];
            cnt    <= cnt + 1'b1;
            borrow <= cell_borrow;
        end
    end

    // Published result and done pulse; d/bout only move at completion.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            d    <= '0;
            bout <= 1'b0;
            done <= 1'b0;
        end else begin
            done <= last_step;
            if (last_step) begin
                d    <= res_shift;
                bout <= cell_borrow;
            end
        end
    end

endmodule
